// File: rtl/spi_ram_ctrl.sv
// SPI frame sequencer + round-robin RAM arbiter (SPI vs host). Uncontended: frame N -> mem_en N+2 -> tx_valid N+4.
// No backpressure on SPI: a one-deep pending slot; a data frame arriving while it is full is dropped and flagged on overrun.
module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [7:0]           host_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t               state;
    logic                 last_gnt_spi;
    logic                 owner_spi;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 spi_pend;
    logic                 pend_we;
    logic [ADDR_SIZE-1:0] pend_addr;
    logic [7:0]           pend_wdata;

    logic                 data_frame;
    logic                 frame_read;
    logic                 sel_spi;
    logic                 sel_host;
    logic                 frame_drop;
    logic [ADDR_SIZE-1:0] payload_addr;

    // Keeps addresses inside a RAM shallower than the address space.
    function automatic logic [ADDR_SIZE-1:0] wrap_addr(input logic [ADDR_SIZE-1:0] a);
        return ADDR_SIZE'(32'(a) % 32'(MEM_DEPTH));
    endfunction

    // Commands 01/11 carry bit 8 set; bit 9 selects read.
    assign data_frame   = rx_valid & rx_data[8];
    assign frame_read   = rx_data[9];
    assign payload_addr = ADDR_SIZE'(rx_data[7:0]);

    // On a tie the requester that was not served last wins.
    assign sel_spi    = (state == ARB) && spi_pend && (!host_req || !last_gnt_spi);
    assign sel_host   = (state == ARB) && host_req && !sel_spi;
    assign frame_drop = data_frame && spi_pend && !sel_spi;
    assign host_gnt   = sel_host && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB;
            last_gnt_spi <= 1'b0;
            owner_spi    <= 1'b0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            spi_pend     <= 1'b0;
            pend_we      <= 1'b0;
            pend_addr    <= '0;
            pend_wdata   <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            host_rvalid  <= 1'b0;
            host_rdata   <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            overrun      <= 1'b0;
        end else begin
            host_rvalid <= 1'b0;

            if (rx_valid) begin
                if (rx_data[9:8] == 2'b00) wr_addr <= payload_addr;
                if (rx_data[9:8] == 2'b10) rd_addr <= payload_addr;
                if (!frame_drop) tx_valid <= 1'b0;
            end

            case (state)
                ARB: begin
                    if (sel_spi) begin
                        mem_en       <= 1'b1;
                        mem_we       <= pend_we;
                        mem_addr     <= wrap_addr(pend_addr);
                        mem_wdata    <= pend_wdata;
                        owner_spi    <= 1'b1;
                        last_gnt_spi <= 1'b1;
                        spi_pend     <= 1'b0;
                        state        <= ACCESS;
                    end else if (sel_host) begin
                        mem_en       <= 1'b1;
                        mem_we       <= host_we;
                        mem_addr     <= wrap_addr(host_addr);
                        mem_wdata    <= host_wdata;
                        owner_spi    <= 1'b0;
                        last_gnt_spi <= 1'b0;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= mem_we ? ARB : RD_WAIT;
                end
                RD_WAIT: begin
                    // A fresh read result wins over a same-edge frame clearing tx_valid.
                    if (owner_spi) begin
                        tx_data  <= mem_rdata;
                        tx_valid <= 1'b1;
                    end else begin
                        host_rdata  <= mem_rdata;
                        host_rvalid <= 1'b1;
                    end
                    state <= ARB;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= ARB;
                end
            endcase

            // After the FSM so a frame accepted on the granting edge refills the slot.
            if (data_frame) begin
                if (frame_drop) begin
                    overrun <= 1'b1;
                end else begin
                    spi_pend   <= 1'b1;
                    pend_we    <= !frame_read;
                    pend_addr  <= frame_read ? rd_addr : wr_addr;
                    pend_wdata <= frame_read ? 8'h00 : rx_data[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed cycle table for spi_ram_ctrl against a small behavioural RAM.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .overrun    (overrun)
    );

    // RAM preloaded with addr ^ 0x5A; survives DUT resets.
    logic       ram_clr;
    logic [7:0] ram [0:255];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
            mem_rdata <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic       rs;
        logic       rxv;
        logic [9:0] rxd;
        logic       hq;
        logic       hw;
        logic [7:0] ha;
        logic [7:0] hd;
        logic       en;
        logic       we;
        logic [7:0] ad;
        logic [7:0] wd;
        logic       tv;
        logic [7:0] td;
        logic       g;
        logic       rv;
        logic [7:0] rd;
        logic       ov;
    } vec_t;

    vec_t vq[$];

    task automatic row(input logic rs, input logic rxv, input logic [9:0] rxd,
                       input logic hq, input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                       input logic en, input logic we, input logic [7:0] ad, input logic [7:0] wd,
                       input logic tv, input logic [7:0] td, input logic g,
                       input logic rv, input logic [7:0] rd, input logic ov);
        vec_t v;
        v.rs = rs; v.rxv = rxv; v.rxd = rxd; v.hq = hq; v.hw = hw; v.ha = ha; v.hd = hd;
        v.en = en; v.we = we; v.ad = ad; v.wd = wd; v.tv = tv; v.td = td;
        v.g = g; v.rv = rv; v.rd = rd; v.ov = ov;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int r, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h, required %h", name, r, act, exp);
        end
    endtask

    initial begin
        // rs rxv rxd     hq hw ha     hd     | en we ad     wd     tv td     g  rv rd     ov
        // write path
        row(0, 1, 10'h010, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // r0
        row(0, 1, 10'h1A5, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // r1 N
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 0); // r3 N+2
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        // read path
        row(0, 1, 10'h210, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // r5
        row(0, 1, 10'h300, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // r6 N
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // r8 N+2
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0); // r10 N+4
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
        row(0, 1, 10'h210, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0); // r12
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        // arbitration from reset: SPI first, then host on the second tie
        row(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // r14
        row(0, 1, 10'h210, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 1, 10'h300, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 1, 10'h230, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // r17 tie
        row(0, 1, 10'h300, 1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 1, 0, 8'h00, 0); // r20 tie 2
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 1, 8'h7A, 0); // r23
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h6A, 0, 0, 8'h00, 0); // r26
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h6A, 0, 0, 8'h00, 0);
        // host write then SPI read-back; data frame accepted on the SPI grant edge
        row(0, 0, 10'h000, 1, 1, 8'h33, 8'h5C, 0, 0, 8'h00, 8'h00, 1, 8'h6A, 1, 0, 8'h00, 0); // r28
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 1, 8'h33, 8'h5C, 1, 8'h6A, 0, 0, 8'h00, 0);
        row(0, 1, 10'h233, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h6A, 0, 0, 8'h00, 0);
        row(0, 1, 10'h300, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 1, 10'h1CC, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0); // r32
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 0, 8'h33, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h5C, 0, 0, 8'h00, 0); // r35
        // overrun while the host owns the RAM
        row(0, 1, 10'h040, 0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 8'hCC, 1, 8'h5C, 0, 0, 8'h00, 0); // r36
        row(0, 1, 10'h1AA, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0);
        row(0, 1, 10'h1BB, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1); // r39
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h7A, 1);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'hAA, 0, 8'h00, 0, 0, 8'h00, 1); // r41
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1);
        // reset while an SPI read sits in RD_WAIT
        row(0, 1, 10'h300, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1); // r44
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 0, 8'h33, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1);
        row(1, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1); // r47
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0); // r50
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h6A, 0); // r53
        row(0, 0, 10'h000, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0);

        rst        = 1'b1;
        ram_clr    = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        ram_clr = 1'b0;
        @(negedge clk);
        chk("rst_mem_en",      -1, 8'(mem_en),      8'h00);
        chk("rst_mem_we",      -1, 8'(mem_we),      8'h00);
        chk("rst_mem_addr",    -1, mem_addr,        8'h00);
        chk("rst_mem_wdata",   -1, mem_wdata,       8'h00);
        chk("rst_tx_valid",    -1, 8'(tx_valid),    8'h00);
        chk("rst_tx_data",     -1, tx_data,         8'h00);
        chk("rst_host_gnt",    -1, 8'(host_gnt),    8'h00);
        chk("rst_host_rvalid", -1, 8'(host_rvalid), 8'h00);
        chk("rst_host_rdata",  -1, host_rdata,      8'h00);
        chk("rst_overrun",     -1, 8'(overrun),     8'h00);

        for (int r = 0; r < vq.size(); r++) begin
            @(posedge clk);
            #1;
            rst        = vq[r].rs;
            rx_valid   = vq[r].rxv;
            rx_data    = vq[r].rxd;
            host_req   = vq[r].hq;
            host_we    = vq[r].hw;
            host_addr  = vq[r].ha;
            host_wdata = vq[r].hd;
            @(negedge clk);
            chk("mem_en",      r, 8'(mem_en),      8'(vq[r].en));
            chk("mem_we",      r, 8'(mem_we),      8'(vq[r].we));
            if (vq[r].en) chk("mem_addr", r, mem_addr, vq[r].ad);
            if (vq[r].en && vq[r].we) chk("mem_wdata", r, mem_wdata, vq[r].wd);
            chk("tx_valid",    r, 8'(tx_valid),    8'(vq[r].tv));
            if (vq[r].tv) chk("tx_data", r, tx_data, vq[r].td);
            chk("host_gnt",    r, 8'(host_gnt),    8'(vq[r].g));
            chk("host_rvalid", r, 8'(host_rvalid), 8'(vq[r].rv));
            if (vq[r].rv) chk("host_rdata", r, host_rdata, vq[r].rd);
            chk("overrun",     r, 8'(overrun),     8'(vq[r].ov));
        end

        // Only 0xAA reached 0x40; the dropped 0xBB frame never touched the RAM.
        chk("ram_0x40", -2, ram[8'h40], 8'hAA);
        chk("ram_0x00", -2, ram[8'h00], 8'hCC);

        @(posedge clk);
        #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        host_req = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
